// File: rtl/note_pkg.sv
// Shared constants for the falling-note lane controller: colours, visible area,
// game-state encodings, the per-lane palette and the note slot record.
package note_pkg;

   localparam int unsigned RGB_W = 12;
   localparam int unsigned COORD_W = 10;

   localparam logic [RGB_W-1:0] RED    = 12'hF00;
   localparam logic [RGB_W-1:0] GREEN  = 12'h0F0;
   localparam logic [RGB_W-1:0] BLUE   = 12'h00F;
   localparam logic [RGB_W-1:0] YELLOW = 12'hFF0;
   localparam logic [RGB_W-1:0] WHITE  = 12'hFFF;
   localparam logic [RGB_W-1:0] BLACK  = 12'h000;

   localparam logic [COORD_W-1:0] H_VIS_START = 10'd144;
   localparam logic [COORD_W-1:0] V_VIS_START = 10'd35;
   localparam logic [COORD_W-1:0] H_VIS_END   = 10'd784;
   localparam logic [COORD_W-1:0] V_VIS_END   = 10'd515;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   typedef struct packed {
      logic               valid;
      logic [COORD_W-1:0] y;
   } slot_t;

   // Lane colours repeat every four lanes.
   function automatic logic [RGB_W-1:0] lane_colour(input int unsigned idx);
      logic [RGB_W-1:0] c;
      case (idx % 4)
         0:       c = RED;
         1:       c = GREEN;
         2:       c = BLUE;
         default: c = YELLOW;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/note_lane.sv
// One falling-note lane: DEPTH slots with spawn, per-frame motion, press
// judgement against the hit zone and the note-pixel test for rendering.
module note_lane
   import note_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned LANE_IDX = 0,
   parameter logic [9:0]  LANE_X0  = 10'd224,
   parameter logic [9:0]  LANE_W   = 10'd80,
   parameter logic [9:0]  NOTE_H   = 10'd40,
   parameter logic [9:0]  SPAWN_Y  = 10'd35,
   parameter logic [9:0]  HIT_TOP  = 10'd400,
   parameter logic [9:0]  HIT_BOT  = 10'd475,
   parameter logic [9:0]  SPEED    = 10'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       active,
   input  logic       spawn,
   input  logic       press,
   input  logic       frame_tick,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   output logic       hit_c,
   output logic [3:0] miss_cnt_c,
   output logic       full_c,
   output logic       empty_press_c,
   output logic       pix_c
);

   localparam logic [10:0] X_L       = 11'(LANE_X0) + 11'(LANE_IDX * LANE_W) + 11'd4;
   localparam logic [10:0] X_R       = 11'(LANE_X0) + 11'((LANE_IDX + 1) * LANE_W) - 11'd5;
   localparam logic [10:0] NOTE_SPAN = 11'(NOTE_H) - 11'd1;

   slot_t            slot_q [DEPTH];
   slot_t            slot_d [DEPTH];
   logic [DEPTH-1:0] hit_sel;
   logic [DEPTH-1:0] spawn_sel;
   logic             found_free;
   logic [10:0]      y_end;
   logic [10:0]      y_next;

   // Judgement and free-slot search use start-of-cycle slot state only.
   always_comb begin
      hit_sel       = '0;
      spawn_sel     = '0;
      hit_c         = 1'b0;
      found_free    = 1'b0;
      miss_cnt_c    = '0;
      pix_c         = 1'b0;
      y_end         = '0;
      y_next        = '0;
      for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = slot_q[i];

      for (int i = 0; i < int'(DEPTH); i++) begin
         y_end = 11'(slot_q[i].y) + NOTE_SPAN;
         if (slot_q[i].valid && slot_q[i].y <= HIT_BOT && y_end >= 11'(HIT_TOP) &&
             press && active && !hit_c) begin
            hit_c      = 1'b1;
            hit_sel[i] = 1'b1;
         end
         if (!slot_q[i].valid && !found_free) begin
            found_free   = 1'b1;
            spawn_sel[i] = 1'b1;
         end
         if (slot_q[i].valid && 11'(v_count) >= 11'(slot_q[i].y) && 11'(v_count) <= y_end &&
             11'(h_count) >= X_L && 11'(h_count) <= X_R)
            pix_c = 1'b1;
      end
      full_c        = !found_free;
      empty_press_c = active && press && !hit_c;

      // A hit slot is removed before motion, so it never also counts as a miss.
      for (int i = 0; i < int'(DEPTH); i++) begin
         y_next = 11'(slot_q[i].y) + 11'(SPEED);
         if (clear) begin
            slot_d[i].valid = 1'b0;
         end else if (active) begin
            if (hit_sel[i]) begin
               slot_d[i].valid = 1'b0;
            end else if (slot_q[i].valid) begin
               if (frame_tick) begin
                  slot_d[i].y = y_next[9:0];
                  if (y_next > 11'(HIT_BOT)) begin
                     slot_d[i].valid = 1'b0;
                     miss_cnt_c      = miss_cnt_c + 4'd1;
                  end
               end
            end else if (spawn && spawn_sel[i]) begin
               slot_d[i].valid = 1'b1;
               slot_d[i].y     = SPAWN_Y;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= slot_d[i];
      end
   end

endmodule

// File: rtl/note_lane_controller.sv
// Falling-note game core: NUM_LANES note_lane instances, score/combo/miss
// bookkeeping, IDLE/PLAY/OVER FSM and pixel colour. Optional macro: COMBO_BONUS_EN.
module note_lane_controller
   import note_pkg::*;
#(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned DEPTH     = 4,
   parameter logic [9:0]  LANE_X0   = 10'd224,
   parameter logic [9:0]  LANE_W    = 10'd80,
   parameter logic [9:0]  NOTE_H    = 10'd40,
   parameter logic [9:0]  SPAWN_Y   = 10'd35,
   parameter logic [9:0]  HIT_TOP   = 10'd400,
   parameter logic [9:0]  HIT_BOT   = 10'd475,
   parameter logic [9:0]  SPEED     = 10'd2,
   parameter logic [7:0]  MAX_MISS  = 8'd10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bright,
   input  logic [9:0]           hCount,
   input  logic [9:0]           vCount,
   input  logic                 frame_tick,
   input  logic                 start,
   input  logic                 spawn_valid,
   input  logic [2:0]           spawn_lane,
   input  logic [NUM_LANES-1:0] btn,
   output logic [11:0]          rgb,
   output logic [15:0]          score,
   output logic [7:0]           combo,
   output logic [7:0]           misses,
   output logic [1:0]           game_state,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic                 spawn_drop
);

   localparam logic [10:0] SPAN_END = 11'(LANE_X0) + 11'(NUM_LANES * LANE_W);

   logic [1:0]           state_q, state_d;
   logic [15:0]          score_q, score_d;
   logic [7:0]           combo_q, combo_d;
   logic [7:0]           misses_q, misses_d;
   logic [NUM_LANES-1:0] btn_q;
   logic                 start_q;
   logic                 hit_pulse_q, hit_pulse_d;
   logic                 miss_pulse_q, miss_pulse_d;
   logic                 spawn_drop_q, spawn_drop_d;

   logic                 active, clear, start_rise, lane_ok, sel_full, empty_any, pix_any;
   logic [NUM_LANES-1:0] press, lane_hit, lane_full, lane_empty, lane_pix;
   logic [3:0]           lane_miss [NUM_LANES];
   logic [3:0]           hit_cnt, inc;
   logic [7:0]           miss_sum, score_add;
   logic [16:0]          score_sum;
   logic [8:0]           combo_sum, miss_total;
   logic [11:0]          note_col;

   assign active     = (state_q == ST_PLAY);
   assign start_rise = start && !start_q;
   assign press      = btn & ~btn_q;
   assign lane_ok    = 32'(spawn_lane) < NUM_LANES;

   for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
      note_lane #(
         .DEPTH(DEPTH), .LANE_IDX(g), .LANE_X0(LANE_X0), .LANE_W(LANE_W), .NOTE_H(NOTE_H),
         .SPAWN_Y(SPAWN_Y), .HIT_TOP(HIT_TOP), .HIT_BOT(HIT_BOT), .SPEED(SPEED)
      ) u_lane (
         .clk(clk), .rst(rst), .clear(clear), .active(active),
         .spawn(spawn_valid && spawn_lane == 3'(g)), .press(press[g]),
         .frame_tick(frame_tick), .h_count(hCount), .v_count(vCount),
         .hit_c(lane_hit[g]), .miss_cnt_c(lane_miss[g]), .full_c(lane_full[g]),
         .empty_press_c(lane_empty[g]), .pix_c(lane_pix[g])
      );
   end

   // Game FSM plus cross-lane aggregation of hits, misses and spawn rejects.
   always_comb begin
      state_d  = state_q;
      clear    = 1'b0;
      hit_cnt  = '0;
      miss_sum = '0;
      sel_full = 1'b0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         hit_cnt  = hit_cnt + 4'(lane_hit[i]);
         miss_sum = miss_sum + 8'(lane_miss[i]);
         if (spawn_lane == 3'(i)) sel_full = lane_full[i];
      end
      empty_any = |lane_empty;

      case (state_q)
         ST_IDLE: if (start_rise) begin
            state_d = ST_PLAY;
            clear   = 1'b1;
         end
         ST_PLAY: if (misses_q >= MAX_MISS) state_d = ST_OVER;
         ST_OVER: if (start_rise) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

`ifdef COMBO_BONUS_EN
      inc = ((combo_q >> 3) >= 8'd7) ? 4'd8 : 4'(8'd1 + (combo_q >> 3));
`else
      inc = 4'd1;
`endif
      score_add  = 8'(inc) * 8'(hit_cnt);
      score_sum  = 17'(score_q) + 17'(score_add);
      combo_sum  = 9'(combo_q) + 9'(hit_cnt);
      miss_total = 9'(misses_q) + 9'(miss_sum);

      score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      combo_d  = combo_sum[8] ? 8'hFF : combo_sum[7:0];
      misses_d = miss_total[8] ? 8'hFF : miss_total[7:0];
      if (miss_sum != 8'd0 || empty_any) combo_d = 8'd0;
      if (clear) begin
         score_d  = '0;
         combo_d  = '0;
         misses_d = '0;
      end

      hit_pulse_d  = |lane_hit;
      miss_pulse_d = (miss_sum != 8'd0);
      spawn_drop_d = active && spawn_valid && (!lane_ok || sel_full);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         score_q      <= '0;
         combo_q      <= '0;
         misses_q     <= '0;
         btn_q        <= '0;
         start_q      <= 1'b0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         spawn_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         combo_q      <= combo_d;
         misses_q     <= misses_d;
         btn_q        <= btn;
         start_q      <= start;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         spawn_drop_q <= spawn_drop_d;
      end
   end

   // Pixel colour is combinational from the current counters.
   always_comb begin
      pix_any  = 1'b0;
      note_col = BLACK;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (lane_pix[i] && !pix_any) begin
            pix_any  = 1'b1;
            note_col = lane_colour(i);
         end
      end
      if (!bright)
         rgb = BLACK;
      else if (pix_any)
         rgb = note_col;
      else if (vCount >= HIT_TOP && vCount <= HIT_BOT &&
               11'(hCount) >= 11'(LANE_X0) && 11'(hCount) < SPAN_END)
         rgb = WHITE;
      else
         rgb = (state_q == ST_OVER) ? RED : BLACK;
   end

   assign score      = score_q;
   assign combo      = combo_q;
   assign misses     = misses_q;
   assign game_state = state_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign spawn_drop = spawn_drop_q;

endmodule

// File: doc/note_lane_controller.md
Name: note_lane_controller

Overview:
- Parametrised successor to the single-block VGA controller: renders and runs NUM_LANES falling-note lanes, each holding up to DEPTH notes, with a shared horizontal hit zone.
- Sits between display_controller (bright, hCount, vCount) and the top level. Spawns notes on request, advances them once per frame, judges button presses against the hit zone, and keeps score, combo and miss counts.
- A game FSM (IDLE/PLAY/OVER) gates all motion.

Parameters:
- NUM_LANES, 4, number of lanes (1..8).
- DEPTH, 4, note slots per lane (1..8).
- LANE_X0, 10'd224, hCount of lane 0 left edge.
- LANE_W, 10'd80, lane width in pixels.
- NOTE_H, 10'd40, note height in pixels.
- SPAWN_Y, 10'd35, note top y at spawn (first visible line).
- HIT_TOP, 10'd400, hit zone first line.
- HIT_BOT, 10'd475, hit zone last line.
- SPEED, 10'd2, pixels moved per frame_tick.
- MAX_MISS, 8'd10, miss count that ends the game.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- bright, in, 1, display-area flag.
- hCount, in, 10, horizontal pixel counter.
- vCount, in, 10, vertical pixel counter.
- frame_tick, in, 1, one-cycle pulse per frame.
- start, in, 1, level; sampled on rising edge.
- spawn_valid, in, 1, spawn request.
- spawn_lane, in, 3, target lane of the spawn.
- btn, in, NUM_LANES, debounced, synchronised lane buttons.
- rgb, out, 12, pixel colour.
- score, out, 16, saturating hit score.
- combo, out, 8, consecutive hits, saturating.
- misses, out, 8, miss count.
- game_state, out, 2, 0 = IDLE, 1 = PLAY, 2 = OVER.
- hit_pulse, out, 1, one cycle per judged hit.
- miss_pulse, out, 1, one cycle per miss.
- spawn_drop, out, 1, one cycle when a spawn is rejected.

Behaviour:
- Reset (asynchronous): all slots invalid; score = 0, combo = 0, misses = 0; game_state = IDLE; all pulses 0; edge registers 0.
- FSM transitions:
  - IDLE → PLAY on start rising edge; clears score, combo, misses and all slots.
  - PLAY → OVER in the cycle after misses reaches MAX_MISS.
  - OVER → IDLE on start rising edge.
- Spawn, frame motion and press judgement act only in PLAY. In IDLE/OVER the notes freeze and are still drawn.
- Slot: valid bit plus 10-bit top y. A note covers rows y..y+NOTE_H-1.
- Spawn:
  - On spawn_valid with spawn_lane < NUM_LANES, the lowest-index free slot gets valid = 1, y = SPAWN_Y.
  - If the lane is full or spawn_lane >= NUM_LANES, spawn_drop = 1 for one cycle and nothing changes.
- Motion: on frame_tick, every valid note does y <= y + SPEED. If the new y > HIT_BOT, the slot is invalidated and counted as a miss.
- Press:
  - press[i] = btn[i] & ~btn_q[i], with btn_q registered.
  - The press hits the lowest-index valid slot in lane i with y <= HIT_BOT and y+NOTE_H-1 >= HIT_TOP, evaluated on pre-update y.
  - On a hit: the slot is invalidated, score += increment, combo += 1.
  - On a press with no eligible note: combo = 0, no score change, no miss.
- Same-cycle events:
  - Press and frame_tick: the press is judged first; the hit slot is not moved.
  - Spawn into a slot freed the same cycle is not allowed; free status is sampled at the start of the cycle.
- Pulse aggregation across lanes:
  - hit_pulse = OR of all lane hits in that cycle.
  - score adds increment × number of hits.
  - Any miss in the cycle sets combo = 0 and misses += number of misses, saturating at 255.
  - A hit and a miss in the same cycle: combo = 0, after the hits are scored.
- Saturation: score at 16'hFFFF, combo at 8'hFF.
- Rendering (combinational, priority order):
  1. ~bright → 0.
  2. Note pixel → lane colour (lane i uses palette entry i mod 4). A note pixel has hCount in [LANE_X0+i·LANE_W+4, LANE_X0+(i+1)·LANE_W−5] and vCount in [y, y+NOTE_H−1].
  3. Hit zone → WHITE: vCount in [HIT_TOP, HIT_BOT], hCount within the lane span.
  4. Otherwise BLACK; in OVER, RED.

Optional Feature:
- COMBO_BONUS_EN defined: increment = 1 + (combo >> 3), using combo before this cycle's update; capped at 8.
- Not defined: increment = 1.

Decomposition:
- Shared package note_pkg:
  - Colour constants: RED, GREEN, BLUE, YELLOW, WHITE, BLACK.
  - Visible-area constants: 144/35/784/515.
  - Game-state encodings and the lane palette.
- Sub-module note_lane, instantiated NUM_LANES times:
  - Holds the DEPTH slots, spawn, motion, press judgement and the pixel-hit output.
  - Outputs per-cycle hit, miss and full flags to the top, which aggregates scores and runs the FSM.

Test Plan:
- Reset mid-PLAY with 3 notes live → all slots invalid, score = 0, game_state = IDLE, rgb shows no notes.
- start edge, spawn lane 1, 183 frame_ticks (y = 35 + 366 = 401), press btn[1] → hit_pulse = 1, score = 1, combo = 1, slot freed.
- Spawn lane 0, no press until y passes 475 (frame 221, y = 477) → miss_pulse = 1, misses = 1, combo = 0.
- Spawn 5 times into lane 2 with DEPTH = 4 → 5th cycle spawn_drop = 1, 4 notes valid.
- Hold btn[0] high for 10 cycles with a note in the zone → exactly one hit; press on an empty lane → combo reset to 0, score unchanged.
- MAX_MISS = 2, two notes missed → game_state = 2 the following cycle, background RED; further frame_ticks leave y unchanged. With COMBO_BONUS_EN, the 9th consecutive hit adds 2.
